// File: rtl/led_channel_calibrator_pkg.sv
// Shared definitions for the LED channel calibrator.
//   state_t    : calibration / replay state machine encoding
//   mid_code   : mid-scale code of a w-bit converter (2^(w-1))
//   clip_hi    : upper clip threshold of a w-bit converter for a given guard band
//   width_of   : index width for n items, never narrower than one bit
package led_channel_calibrator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DC_TRIAL,
        ST_DC_VERIFY,
        ST_GAIN_EVAL,
        ST_NEXT_CH,
        ST_RUN
    } state_t;

    function automatic int unsigned mid_code(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned clip_hi(input int unsigned w, input int unsigned guard);
        return (32'd1 << w) - 32'd1 - guard;
    endfunction

    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_channel_calibrator_stats.sv
// calib_window_stats: running minimum / maximum over a window of WIN samples.
//   clk, rst   : clock and synchronous active-high reset
//   clear      : restart the window (min to all-ones, max to zero, count to zero)
//   sample_en  : accept 'sample' this cycle (ignored once the window is full)
//   sample     : W-bit input sample
//   min_val    : smallest sample seen in the current window
//   max_val    : largest sample seen in the current window
//   count      : number of samples accepted so far
//   done       : one-cycle strobe; min_val/max_val already include the last sample
module calib_window_stats #(
    parameter int W   = 8,
    parameter int WIN = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       sample_en,
    input  logic [W-1:0]               sample,
    output logic [W-1:0]               min_val,
    output logic [W-1:0]               max_val,
    output logic [$clog2(WIN+1)-1:0]   count,
    output logic                       done
);

    localparam int CNT_W = $clog2(WIN + 1);

    logic [W-1:0]     min_q, min_d;
    logic [W-1:0]     max_q, max_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    // Samples arriving after the window is full are dropped, so the result
    // stays frozen until the owner clears it.
    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (clear) begin
            min_d   = '1;
            max_d   = '0;
            count_d = '0;
        end else if (sample_en && (count_q != CNT_W'(WIN))) begin
            if (sample < min_q) begin
                min_d = sample;
            end
            if (sample > max_q) begin
                max_d = sample;
            end
            count_d = count_q + CNT_W'(1);
            done_d  = (count_q == CNT_W'(WIN - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q   <= '1;
            max_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign min_val = min_q;
    assign max_val = max_q;
    assign count   = count_q;
    assign done    = done_q;

endmodule

// File: rtl/led_channel_calibrator.sv
// led_channel_calibrator: per-channel DC compensation and PGA gain calibration
// for an N_CH-LED optical front end, followed by time-multiplexed replay.
//   clk, rst      : clock and synchronous active-high reset
//   find_setting  : start / restart calibration from IDLE or RUN
//   adc           : ADC sample, valid every cycle
//   dc_comp       : DC compensation DAC code
//   pga_gain      : PGA gain code
//   led_en        : one-hot LED enable (zero in IDLE)
//   ch_sel        : active channel index
//   busy          : calibration in progress
//   done          : one-cycle pulse when the last channel is calibrated
//   fail          : per-channel DC-search failure, cleared on each start
// All outputs come straight from flops.
module led_channel_calibrator
    import led_channel_calibrator_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ADC_W     = 8,
    parameter int DC_W      = 7,
    parameter int GAIN_W    = 4,
    parameter int SETTLE    = 4,
    parameter int WIN       = 16,
    parameter int TOL       = 4,
    parameter int SWING_TGT = 64,
    parameter int GUARD     = 16,
    parameter int SLOT      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      find_setting,
    input  logic [ADC_W-1:0]          adc,
    output logic [DC_W-1:0]           dc_comp,
    output logic [GAIN_W-1:0]         pga_gain,
    output logic [N_CH-1:0]           led_en,
    output logic [width_of(N_CH)-1:0] ch_sel,
    output logic                      busy,
    output logic                      done,
    output logic [N_CH-1:0]           fail
);

    localparam int CH_W   = width_of(N_CH);
    localparam int BIT_W  = width_of(DC_W);
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int SLOT_W = width_of(SLOT);
    localparam int CNT_W  = $clog2(WIN + 1);

    localparam logic [DC_W-1:0]  DC_RST   = DC_W'(mid_code(DC_W));
    localparam logic [ADC_W-1:0] MID      = ADC_W'(mid_code(ADC_W));
    localparam logic [ADC_W-1:0] CLIP_LO  = ADC_W'(GUARD);
    localparam logic [ADC_W-1:0] CLIP_HI  = ADC_W'(clip_hi(ADC_W, GUARD));
    localparam logic [ADC_W-1:0] TOL_C    = ADC_W'(TOL);
    localparam logic [ADC_W:0]   TGT_C    = (ADC_W + 1)'(SWING_TGT);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [SET_W-1:0] SETTLE_C = SET_W'(SETTLE);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [DC_W-1:0]     dc_comp_q, dc_comp_d;
    logic [GAIN_W-1:0]   pga_gain_q, pga_gain_d;
    logic [N_CH-1:0]     led_en_q, led_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_CH-1:0]     fail_q, fail_d;
    logic [DC_W-1:0]     dc_mem_q [N_CH];
    logic [DC_W-1:0]     dc_mem_d [N_CH];
    logic [GAIN_W-1:0]   gain_mem_q [N_CH];
    logic [GAIN_W-1:0]   gain_mem_d [N_CH];

    logic                stats_clear;
    logic                stats_sample_en;
    logic [ADC_W-1:0]    stats_min;
    logic [ADC_W-1:0]    stats_max;
    logic [CNT_W-1:0]    stats_count;
    logic                stats_done;

    logic [ADC_W-1:0]    adc_err;
    logic [DC_W-1:0]     bit_mask;
    logic [DC_W-1:0]     code_kept;
    logic [ADC_W-1:0]    swing;
    logic                clipped;
    logic [CH_W-1:0]     run_next;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) begin
            v[i] = (idx == CH_W'(i));
        end
        return v;
    endfunction

    // The window only collects while GAIN_EVAL has finished settling; at any
    // other time it is held cleared so each gain step starts from scratch.
    assign stats_clear     = !((state_q == ST_GAIN_EVAL) && (settle_q == '0));
    assign stats_sample_en = (state_q == ST_GAIN_EVAL) && (settle_q == '0) &&
                             (stats_count != CNT_W'(WIN));

    calib_window_stats #(
        .W   (ADC_W),
        .WIN (WIN)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .clear     (stats_clear),
        .sample_en (stats_sample_en),
        .sample    (adc),
        .min_val   (stats_min),
        .max_val   (stats_max),
        .count     (stats_count),
        .done      (stats_done)
    );

    // Datapath helpers: |adc-MID| without wrap, the SAR keep/clear decision
    // for the bit under trial, and the window evaluation terms.
    always_comb begin
        adc_err   = (adc >= MID) ? (adc - MID) : (MID - adc);
        bit_mask  = DC_W'(1) << bit_q;
        code_kept = (adc > MID) ? dc_comp_q : (dc_comp_q & ~bit_mask);
        swing     = stats_max - stats_min;
        clipped   = (stats_min <= CLIP_LO) || (stats_max >= CLIP_HI);
        run_next  = (ch_q == LAST_CH) ? '0 : (ch_q + CH_W'(1));
    end

    // Next-state and registered-output logic. Every output flop is loaded
    // here so that channel, LED, DAC and gain always switch on the same edge.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        bit_d      = bit_q;
        settle_d   = settle_q;
        slot_d     = slot_q;
        dc_comp_d  = dc_comp_q;
        pga_gain_d = pga_gain_q;
        led_en_d   = led_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fail_d     = fail_q;
        dc_mem_d   = dc_mem_q;
        gain_mem_d = gain_mem_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (find_setting) begin
                    state_d    = ST_DC_TRIAL;
                    busy_d     = 1'b1;
                    fail_d     = '0;
                    ch_d       = '0;
                    bit_d      = BIT_W'(DC_W - 1);
                    dc_comp_d  = DC_RST;
                    pga_gain_d = '0;
                    led_en_d   = onehot('0);
                    settle_d   = SETTLE_C;
                end else if (state_q == ST_RUN) begin
                    if (slot_q == '0) begin
                        ch_d       = run_next;
                        dc_comp_d  = dc_mem_q[run_next];
                        pga_gain_d = gain_mem_q[run_next];
                        led_en_d   = onehot(run_next);
                        slot_d     = SLOT_W'(SLOT - 1);
                    end else begin
                        slot_d = slot_q - SLOT_W'(1);
                    end
                end
            end

            ST_DC_TRIAL: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SET_W'(1);
                end else if (bit_q == '0) begin
                    dc_comp_d = code_kept;
                    state_d   = ST_DC_VERIFY;
                    settle_d  = SETTLE_C;
                end else begin
                    bit_d     = bit_q - BIT_W'(1);
                    dc_comp_d = code_kept | (DC_W'(1) << (bit_q - BIT_W'(1)));
                    settle_d  = SETTLE_C;
                end
            end

            ST_DC_VERIFY: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SET_W'(1);
                end else begin
                    if (adc_err > TOL_C) begin
                        fail_d[ch_q] = 1'b1;
                    end
                    dc_mem_d[ch_q] = dc_comp_q;
                    state_d        = ST_GAIN_EVAL;
                    pga_gain_d     = '0;
                    settle_d       = SETTLE_C;
                end
            end

            ST_GAIN_EVAL: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SET_W'(1);
                end else if (stats_done) begin
                    if (clipped) begin
                        // Back off one step; gain 0 that clips is kept at 0.
                        pga_gain_d       = (pga_gain_q == '0) ? '0 : (pga_gain_q - GAIN_W'(1));
                        gain_mem_d[ch_q] = (pga_gain_q == '0) ? '0 : (pga_gain_q - GAIN_W'(1));
                        state_d          = ST_NEXT_CH;
                    end else if (({1'b0, swing} >= TGT_C) || (pga_gain_q == '1)) begin
                        gain_mem_d[ch_q] = pga_gain_q;
                        state_d          = ST_NEXT_CH;
                    end else begin
                        pga_gain_d = pga_gain_q + GAIN_W'(1);
                        settle_d   = SETTLE_C;
                    end
                end
            end

            ST_NEXT_CH: begin
                if (ch_q == LAST_CH) begin
                    state_d    = ST_RUN;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    ch_d       = '0;
                    dc_comp_d  = dc_mem_q[0];
                    pga_gain_d = gain_mem_q[0];
                    led_en_d   = onehot('0);
                    slot_d     = SLOT_W'(SLOT - 1);
                end else begin
                    state_d    = ST_DC_TRIAL;
                    ch_d       = ch_q + CH_W'(1);
                    bit_d      = BIT_W'(DC_W - 1);
                    dc_comp_d  = DC_RST;
                    pga_gain_d = '0;
                    led_en_d   = onehot(ch_q + CH_W'(1));
                    settle_d   = SETTLE_C;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            bit_q      <= '0;
            settle_q   <= '0;
            slot_q     <= '0;
            dc_comp_q  <= DC_RST;
            pga_gain_q <= '0;
            led_en_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dc_mem_q[i]   <= DC_RST;
                gain_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            bit_q      <= bit_d;
            settle_q   <= settle_d;
            slot_q     <= slot_d;
            dc_comp_q  <= dc_comp_d;
            pga_gain_q <= pga_gain_d;
            led_en_q   <= led_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            dc_mem_q   <= dc_mem_d;
            gain_mem_q <= gain_mem_d;
        end
    end

    assign dc_comp  = dc_comp_q;
    assign pga_gain = pga_gain_q;
    assign led_en   = led_en_q;
    assign ch_sel   = ch_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;

endmodule
